// File: rtl/db_pkg.sv
// Shared definitions for the multi-channel debouncer: FSM state codes and
// the sizing helper for the per-channel tick counter.
package db_pkg;

  localparam logic [1:0] ZERO  = 2'd0;
  localparam logic [1:0] WAIT1 = 2'd1;
  localparam logic [1:0] ONE   = 2'd2;
  localparam logic [1:0] WAIT0 = 2'd3;

  function automatic int cnt_width(input int k);
    return (k < 1) ? 1 : $clog2(k + 1);
  endfunction

endpackage

// File: rtl/db_chan.sv
// One debounce channel: two-flop synchroniser, stable-tick FSM with counter,
// and registered rise/fall event pulses.
module db_chan
  import db_pkg::*;
#(
  parameter int K          = 3,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sw_raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int             CW       = cnt_width(K);
  localparam logic [CW-1:0]  CNT_LAST = CW'(K - 1);

  logic          sync1_q, sync1_d;
  logic          s_q, s_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      state_q <= ZERO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      s_q     <= s_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Reversion of s is tested before the tick, so a late bounce always wins.
  always_comb begin
    sync1_d = sw_raw ^ ACTIVE_LOW;
    s_d     = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ZERO: if (s_q) begin
        state_d = WAIT1;
        cnt_d   = '0;
      end
      WAIT1: begin
        if (!s_q) state_d = ZERO;
        else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ONE;
            rise_d  = 1'b1;
          end else cnt_d = cnt_q + CW'(1);
        end
      end
      ONE: if (!s_q) begin
        state_d = WAIT0;
        cnt_d   = '0;
      end
      WAIT0: begin
        if (s_q) state_d = ONE;
        else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ZERO;
            fall_d  = 1'b1;
          end else cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  assign db   = (state_q == ONE) || (state_q == WAIT0);
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/db_multi.sv
// CH independent switch debouncers sharing one free-running tick prescaler.
module db_multi #(
  parameter int CH         = 4,
  parameter int N          = 19,
  parameter int K          = 3,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          tick
);

  logic [N-1:0] presc_q, presc_d;

  always_comb presc_d = presc_q + N'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  // Tick is the wrap cycle, so it is already high in the first cycle after reset.
  assign tick = (presc_q == '0);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    db_chan #(
      .K         (K),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .sw_raw(sw[i]),
      .db    (db[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: tb/tb_db_multi.sv
// Scoreboard bench for db_multi: two instances (K=3 active-high, K=1 active-low).
module tb_db_multi;

  typedef struct {
    int ch;
    int cyc;
    bit is_rise;
  } ev_t;

  logic       clk;
  logic       rst_a, rst_b;
  logic [1:0] sw_a, sw_b;
  logic [1:0] db_a, rise_a, fall_a;
  logic [1:0] db_b, rise_b, fall_b;
  logic       tick_a, tick_b;
  int         cyc_a, cyc_b;
  int         checks = 0;
  int         errors = 0;
  ev_t        sb_a[$];
  ev_t        sb_b[$];

  db_multi #(.CH(2), .N(3), .K(3), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .reset(rst_a), .sw(sw_a), .db(db_a), .rise(rise_a), .fall(fall_a), .tick(tick_a)
  );

  db_multi #(.CH(2), .N(3), .K(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .sw(sw_b), .db(db_b), .rise(rise_b), .fall(fall_b), .tick(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release; equals the prescaler value modulo 8.
  always @(posedge clk or posedge rst_a)
    if (rst_a) cyc_a <= 0;
    else       cyc_a <= cyc_a + 1;

  always @(posedge clk or posedge rst_b)
    if (rst_b) cyc_b <= 0;
    else       cyc_b <= cyc_b + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Cycle in which db changes for an sw edge driven in cycle c.
  function automatic int pred(input int c, input int k);
    int f;
    f = ((c + 3 + 7) / 8) * 8;
    return f + (k - 1) * 8 + 1;
  endfunction

  task automatic push(input int d, input int ch, input int cyc, input bit is_rise);
    ev_t e;
    e.ch = ch; e.cyc = cyc; e.is_rise = is_rise;
    if (d == 0) sb_a.push_back(e);
    else        sb_b.push_back(e);
  endtask

  task automatic mon(input int d, input logic rstv, input int c, input logic tk,
                     input logic [1:0] dbv, input logic [1:0] r, input logic [1:0] f);
    ev_t e;
    bit  empty;
    if (rstv) return;
    chk(d == 0 ? "tick_a" : "tick_b", tk, (c % 8) == 0);
    for (int i = 0; i < 2; i++) begin
      if (r[i] || f[i]) begin
        chk("rise_fall_excl", r[i] & f[i], 0);
        empty = (d == 0) ? (sb_a.size() == 0) : (sb_b.size() == 0);
        if (empty) chk("spurious_pulse", {r[i], f[i]}, 0);
        else begin
          if (d == 0) e = sb_a.pop_front();
          else        e = sb_b.pop_front();
          chk("ev_cyc", c, e.cyc);
          chk("ev_ch", i, e.ch);
          chk("ev_is_rise", r[i], e.is_rise);
          chk("ev_db", dbv[i], e.is_rise);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst_a, cyc_a, tick_a, db_a, rise_a, fall_a);
    mon(1, rst_b, cyc_b, tick_b, db_b, rise_b, fall_b);
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int d, input int target);
    int n = 0;
    while (((d == 0) ? cyc_a : cyc_b) < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("timeout", (d == 0) ? cyc_a : cyc_b, target);
  endtask

  task automatic wait_phase(input int d, input int p);
    do @(negedge clk); while ((((d == 0) ? cyc_a : cyc_b) % 8) != p);
  endtask

  initial begin
    int c, t, f;
    rst_a = 1'b1; rst_b = 1'b1;
    sw_a = 2'b00; sw_b = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_db_a", db_a, 0);
    chk("rst_rise_a", rise_a, 0);
    chk("rst_fall_a", fall_a, 0);
    @(negedge clk);
    rst_a = 1'b0;

    // Clean press on channel 0
    wait_n(5);
    c = cyc_a; sw_a[0] = 1'b1;
    t = pred(c, 3); push(0, 0, t, 1'b1);
    wait_until(0, t - 1);
    chk("press_db_before", db_a, 2'b00);
    wait_until(0, t + 2);
    chk("press_db", db_a, 2'b01);

    // 12-cycle glitch on channel 1
    sw_a[1] = 1'b1;
    wait_n(12);
    sw_a[1] = 1'b0;
    wait_n(40);
    chk("glitch_db", db_a, 2'b01);

    // Release with three single-cycle bounces
    sw_a[0] = 1'b0; wait_n(2);
    sw_a[0] = 1'b1; wait_n(1);
    sw_a[0] = 1'b0; wait_n(2);
    sw_a[0] = 1'b1; wait_n(1);
    sw_a[0] = 1'b0; wait_n(2);
    sw_a[0] = 1'b1; wait_n(1);
    sw_a[0] = 1'b0;
    c = cyc_a; t = pred(c, 3); push(0, 0, t, 1'b0);
    wait_until(0, t - 1);
    chk("bounce_db_hold", db_a, 2'b01);
    wait_until(0, t + 1);
    chk("bounce_db", db_a, 2'b00);

    // Simultaneous press on both channels
    wait_n(3);
    c = cyc_a; sw_a = 2'b11;
    t = pred(c, 3); push(0, 0, t, 1'b1); push(0, 1, t, 1'b1);
    wait_until(0, t + 1);
    chk("simul_db", db_a, 2'b11);

    // Release ch0 and bring it back so s is 1 exactly in the final-tick cycle
    wait_phase(0, 0);
    c = cyc_a; sw_a[0] = 1'b0;
    f = ((c + 3 + 7) / 8) * 8;
    wait_until(0, f + 16 - 2);
    sw_a[0] = 1'b1;
    wait_n(30);
    chk("revert_db", db_a, 2'b11);

    // Reset while both channels are mid-debounce
    sw_a = 2'b00;
    wait_n(6);
    rst_a = 1'b1;
    #1;
    chk("midrst_db_a", db_a, 0);
    chk("midrst_rise_a", rise_a, 0);
    chk("midrst_fall_a", fall_a, 0);
    @(negedge clk);
    wait_n(2);
    rst_a = 1'b0;
    wait_n(40);
    chk("postrst_db_a", db_a, 0);

    // Active-low, K=1 instance
    rst_b = 1'b0;
    wait_n(4);
    chk("b_rst_db", db_b, 0);
    c = cyc_b; sw_b[0] = 1'b0;
    t = pred(c, 1); push(1, 0, t, 1'b1);
    wait_until(1, t + 1);
    chk("b_press_db", db_b, 2'b01);
    wait_phase(1, 1);
    sw_b[0] = 1'b1;
    wait_phase(1, 6);
    rst_b = 1'b1;
    #1;
    chk("b_midrst_db", db_b, 0);
    chk("b_midrst_fall", fall_b, 0);
    @(negedge clk);
    wait_n(2);
    rst_b = 1'b0;
    wait_n(20);
    chk("b_postrst_db", db_b, 0);

    chk("sb_a_empty", sb_a.size(), 0);
    chk("sb_b_empty", sb_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
